// File: rtl/cov_event_monitor.sv
// cov_event_monitor
// Downstream checker for the coverage-experiment DUT. Counts rising edges of
// in1/in2/in3 inside a start/stop measurement window, flags in1/in2 overlap,
// and measures the spacing of in3 rising edges against EXP_PERIOD.
//
// Command interface: start, stop and clr are single-cycle pulses sampled on
// every rising CLK edge. There is no valid/ready handshake. clr wins over stop,
// and stop wins over start. Results are valid whenever done is high and hold
// until the next start or clr.
//
// fsm_state exposes the FSM encoding for debug and checker binding:
// 0=IDLE 1=ARMED 2=RUN 3=DONE.

module cov_event_monitor #(
  parameter int CNT_W      = 8,
  parameter int PER_W      = 4,
  parameter int EXP_PERIOD = 3
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  input  logic             in1,
  input  logic             in2,
  input  logic             in3,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  output logic [PER_W-1:0] last_period,
  output logic             period_err,
  output logic             excl_err,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PER_W-1:0] PER_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);
  localparam logic [PER_W-1:0] EXP_P   = PER_W'(EXP_PERIOD);

  state_e           state_q, state_d;
  logic             prev1_q, prev2_q, prev3_q;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;
  logic [CNT_W-1:0] cnt3_q, cnt3_d;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [PER_W-1:0] last_period_q, last_period_d;
  logic             period_err_q, period_err_d;
  logic             excl_err_q, excl_err_d;

  logic edge1, edge2, edge3;
  logic overlap;

  // Rising edges relative to last cycle's input, independent of FSM state.
  assign edge1   = in1 & ~prev1_q;
  assign edge2   = in2 & ~prev2_q;
  assign edge3   = in3 & ~prev3_q;
  assign overlap = in1 & in2;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [PER_W-1:0] per_sat_inc(input logic [PER_W-1:0] v);
    return (v == PER_MAX) ? v : v + PER_ONE;
  endfunction

  // Edge history registers track the inputs every cycle; clr leaves them alone.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      prev1_q <= 1'b0;
      prev2_q <= 1'b0;
      prev3_q <= 1'b0;
    end else begin
      prev1_q <= in1;
      prev2_q <= in2;
      prev3_q <= in3;
    end
  end

  // FSM next state plus all result next-values, defaults hold current values.
  always_comb begin
    state_d       = state_q;
    cnt1_d        = cnt1_q;
    cnt2_d        = cnt2_q;
    cnt3_d        = cnt3_q;
    per_cnt_d     = per_cnt_q;
    last_period_d = last_period_q;
    period_err_d  = period_err_q;
    excl_err_d    = excl_err_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // stop outranks start even though stop itself has no effect here.
        if (start && !stop) begin
          cnt1_d        = '0;
          cnt2_d        = '0;
          cnt3_d        = '0;
          per_cnt_d     = '0;
          last_period_d = '0;
          period_err_d  = 1'b0;
          excl_err_d    = 1'b0;
          state_d       = S_ARMED;
        end
      end

      S_ARMED: begin
        if (edge1)   cnt1_d = cnt_sat_inc(cnt1_q);
        if (edge2)   cnt2_d = cnt_sat_inc(cnt2_q);
        if (overlap) excl_err_d = 1'b1;
        // First in3 edge only starts the period measurement.
        if (edge3) begin
          cnt3_d    = CNT_ONE;
          per_cnt_d = PER_ONE;
          state_d   = S_RUN;
        end
        if (stop) state_d = S_DONE;
      end

      S_RUN: begin
        if (edge1)   cnt1_d = cnt_sat_inc(cnt1_q);
        if (edge2)   cnt2_d = cnt_sat_inc(cnt2_q);
        if (overlap) excl_err_d = 1'b1;
        per_cnt_d = per_sat_inc(per_cnt_q);
        if (edge3) begin
          cnt3_d        = cnt_sat_inc(cnt3_q);
          last_period_d = per_cnt_q;
          if (per_cnt_q != EXP_P) period_err_d = 1'b1;
          per_cnt_d     = PER_ONE;
        end
        if (stop) state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase

    if (clr) begin
      cnt1_d        = '0;
      cnt2_d        = '0;
      cnt3_d        = '0;
      per_cnt_d     = '0;
      last_period_d = '0;
      period_err_d  = 1'b0;
      excl_err_d    = 1'b0;
      state_d       = S_IDLE;
    end
  end

  // State and result registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= S_IDLE;
      cnt1_q        <= '0;
      cnt2_q        <= '0;
      cnt3_q        <= '0;
      per_cnt_q     <= '0;
      last_period_q <= '0;
      period_err_q  <= 1'b0;
      excl_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt1_q        <= cnt1_d;
      cnt2_q        <= cnt2_d;
      cnt3_q        <= cnt3_d;
      per_cnt_q     <= per_cnt_d;
      last_period_q <= last_period_d;
      period_err_q  <= period_err_d;
      excl_err_q    <= excl_err_d;
    end
  end

  assign cnt1        = cnt1_q;
  assign cnt2        = cnt2_q;
  assign cnt3        = cnt3_q;
  assign last_period = last_period_q;
  assign period_err  = period_err_q;
  assign excl_err    = excl_err_q;
  assign busy        = (state_q == S_ARMED) || (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_cov_event_monitor.sv
// Bench for cov_event_monitor: directed windows with expected results queued
// as stimulus is driven and compared once the window reports done.

module tb_cov_event_monitor;

  localparam int CNT_W = 8;
  localparam int PER_W = 4;

  localparam int ST_IDLE = 0;
  localparam int ST_DONE = 3;

  // Clock and reset
  logic CLK;
  logic RSTn;
  logic start, stop, clr, in1, in2, in3;
  logic [CNT_W-1:0] cnt1, cnt2, cnt3;
  logic [PER_W-1:0] last_period;
  logic period_err, excl_err, busy, done;
  logic [1:0] fsm_state;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  cov_event_monitor #(.CNT_W(CNT_W), .PER_W(PER_W), .EXP_PERIOD(3)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .stop(stop), .clr(clr),
    .in1(in1), .in2(in2), .in3(in3),
    .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .last_period(last_period),
    .period_err(period_err), .excl_err(excl_err), .busy(busy), .done(done),
    .fsm_state(fsm_state)
  );

  // Scoreboard
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_results(input string name,
                              input int c1, input int c2, input int c3,
                              input int lp, input int pe, input int ee,
                              input int b, input int d, input int st);
    exp_q.push_back(32'(c1)); tag_q.push_back({name, "_cnt1"});
    exp_q.push_back(32'(c2)); tag_q.push_back({name, "_cnt2"});
    exp_q.push_back(32'(c3)); tag_q.push_back({name, "_cnt3"});
    exp_q.push_back(32'(lp)); tag_q.push_back({name, "_last_period"});
    exp_q.push_back(32'(pe)); tag_q.push_back({name, "_period_err"});
    exp_q.push_back(32'(ee)); tag_q.push_back({name, "_excl_err"});
    exp_q.push_back(32'(b));  tag_q.push_back({name, "_busy"});
    exp_q.push_back(32'(d));  tag_q.push_back({name, "_done"});
    exp_q.push_back(32'(st)); tag_q.push_back({name, "_state"});
  endtask

  // Pops one result set and compares it with the DUT outputs right now.
  task automatic compare_results();
    logic [31:0] obs [9];
    obs[0] = 32'(cnt1);
    obs[1] = 32'(cnt2);
    obs[2] = 32'(cnt3);
    obs[3] = 32'(last_period);
    obs[4] = 32'(period_err);
    obs[5] = 32'(excl_err);
    obs[6] = 32'(busy);
    obs[7] = 32'(done);
    obs[8] = 32'(fsm_state);
    for (int i = 0; i < 9; i++) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
        break;
      end
      check(tag_q.pop_front(), obs[i], exp_q.pop_front());
    end
  endtask

  // Waits (bounded) for done, then compares the queued result set.
  task automatic wait_done_compare();
    for (int i = 0; i < 8; i++) begin
      if (done) break;
      @(negedge CLK);
    end
    if (!done) begin
      check("done_timeout", 32'(done), 32'd1);
      exp_q.delete();
      tag_q.delete();
    end else begin
      compare_results();
    end
  endtask

  // Driver tasks: inputs change at negedge, one call = one clock cycle.
  task automatic drive(input logic s, input logic p, input logic c,
                       input logic a, input logic b, input logic d);
    start = s; stop = p; clr = c; in1 = a; in2 = b; in3 = d;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  // One in3 pulse followed by gap-1 low cycles, so consecutive pulses are gap apart.
  task automatic in3_pulse(input int gap);
    drive(0, 0, 0, 0, 0, 1);
    idle(gap - 1);
  endtask

  task automatic in1_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
    end
  endtask

  int n_rand, m_rand;

  initial begin
    RSTn = 1'b0;
    start = 0; stop = 0; clr = 0; in1 = 0; in2 = 0; in3 = 0;
    repeat (2) @(negedge CLK);
    push_results("reset", 0, 0, 0, 0, 0, 0, 0, 0, ST_IDLE);
    compare_results();
    RSTn = 1'b1;
    idle($urandom_range(1, 4));

    // 1: four in3 pulses spaced 3 cycles
    drive(1, 0, 0, 0, 0, 0);
    check("t1_busy_armed", 32'(busy), 32'd1);
    in3_pulse(3); in3_pulse(3); in3_pulse(3); in3_pulse(1);
    drive(0, 1, 0, 0, 0, 0);
    push_results("t1", 0, 0, 4, 3, 0, 0, 0, 1, ST_DONE);
    wait_done_compare();

    // 2: one 4-cycle spacing makes period_err sticky
    drive(1, 0, 0, 0, 0, 0);
    in3_pulse(3); in3_pulse(4); in3_pulse(3);
    check("t2_perr_mid", 32'(period_err), 32'd1);
    check("t2_lp_mid", 32'(last_period), 32'd4);
    in3_pulse(3); in3_pulse(1);
    drive(0, 1, 0, 0, 0, 0);
    push_results("t2", 0, 0, 5, 3, 1, 0, 0, 1, ST_DONE);
    wait_done_compare();

    // 3: in1 edges and an in1/in2 overlap
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("t3_excl_before", 32'(excl_err), 32'd0);
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 1, 0, 0, 0, 0);
    push_results("t3", 3, 1, 0, 0, 0, 1, 0, 1, ST_DONE);
    wait_done_compare();

    // 4: cnt1 saturation and per_cnt saturation on a 20-cycle gap
    drive(1, 0, 0, 0, 0, 0);
    in1_pulses($urandom_range(300, 310));
    in3_pulse(20); in3_pulse(1);
    drive(0, 1, 0, 0, 0, 0);
    push_results("t4", 255, 0, 2, 15, 1, 0, 0, 1, ST_DONE);
    wait_done_compare();

    // 5: stop on the same cycle as an in3 edge, then start+clr together
    drive(1, 0, 0, 0, 0, 0);
    in3_pulse(3);
    drive(0, 1, 0, 0, 0, 1);
    push_results("t5", 0, 0, 2, 3, 0, 0, 0, 1, ST_DONE);
    wait_done_compare();
    drive(1, 0, 1, 0, 0, 0);
    push_results("t5_clr", 0, 0, 0, 0, 0, 0, 0, 0, ST_IDLE);
    compare_results();

    // 7: random in1/in2 pulse counts with no overlap
    n_rand = $urandom_range(1, 40);
    m_rand = $urandom_range(0, n_rand);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < n_rand; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, (i < m_rand), 0);
    end
    drive(0, 1, 0, 0, 0, 0);
    push_results("t7", n_rand, m_rand, 0, 0, 0, 0, 0, 1, ST_DONE);
    wait_done_compare();
    drive(0, 0, 0, 1, 0, 0);
    check("t7_hold_cnt1", 32'(cnt1), 32'(n_rand));

    // 6: asynchronous reset in the middle of RUN
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    in3_pulse(2);
    in1_pulses(5);
    check("t6_cnt1_mid", 32'(cnt1), 32'd5);
    check("t6_busy_mid", 32'(busy), 32'd1);
    #2 RSTn = 1'b0;
    #1;
    push_results("t6_rst", 0, 0, 0, 0, 0, 0, 0, 0, ST_IDLE);
    compare_results();
    @(negedge CLK);
    RSTn = 1'b1;
    in1_pulses(3);
    push_results("t6_nostart", 0, 0, 0, 0, 0, 0, 0, 0, ST_IDLE);
    compare_results();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
